// File: rtl/instr_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, single-outstanding imem request,
// one-entry skid buffer for stalls, and the IF/ID register feeding decode.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [5:0]  if_id_opcode,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] skidBuf;
    logic [31:0] redirPc;
    logic [31:0] pcPlus4;

    assign redirPc      = {redirect_pc[31:2], 2'b00};
    assign pcPlus4      = pc + 32'd4;
    assign if_id_opcode = if_id_instr[31:26];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            imem_req    <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            skidBuf     <= NOP_INSTR;
        end else begin
            unique case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                FETCH: begin
                    if (redirect) begin
                        pc          <= redirPc;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        // An unanswered request must keep its address; drain it in DROP.
                        if (imem_ready) imem_addr <= redirPc;
                        else            state     <= DROP;
                    end else if (imem_ready) begin
                        if (stall) begin
                            skidBuf  <= imem_rdata;
                            imem_req <= 1'b0;
                            state    <= HOLD;
                        end else begin
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= pcPlus4;
                            if_id_valid <= 1'b1;
                            pc          <= pcPlus4;
                            imem_addr   <= pcPlus4;
                        end
                    end else if (!stall) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc          <= redirPc;
                        imem_addr   <= redirPc;
                        imem_req    <= 1'b1;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (!stall) begin
                        if_id_instr <= skidBuf;
                        if_id_pc4   <= pcPlus4;
                        if_id_valid <= 1'b1;
                        pc          <= pcPlus4;
                        imem_addr   <= pcPlus4;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DROP: begin
                    // Last redirect wins; the stale response is thrown away.
                    if (redirect) pc <= redirPc;
                    if (imem_ready) begin
                        imem_addr <= redirect ? redirPc : pc;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: per-cycle vector table plus a hand
// sequence covering the in-flight redirect drain.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_opcode;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int nCmp = 0;
    int nBad = 0;

    instr_fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    // Memory content: address-tagged lw-looking word (opcode 6'h23 for small addresses).
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    typedef struct {
        logic        rst, rdy, stl, rdr;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr, pc;
        logic        vld;
        logic [31:0] instr, pc4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, rdy, stl, rdr, input logic [31:0] rpc,
                       input logic req, input logic [31:0] addr, pcv,
                       input logic vld, input logic [31:0] instr, pc4);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
        v.req = req; v.addr = addr; v.pc = pcv; v.vld = vld;
        v.instr = instr; v.pc4 = pc4;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, rdy, stl, rdr, input logic [31:0] rpc);
        @(negedge clk);
        rst = r; imem_ready = rdy; stall = stl; redirect = rdr; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst rdy stl rdr rpc | req addr pc vld instr pc4
        add(1,0,0,0,0,            0,0,0,0,0,0);
        add(1,0,0,0,0,            0,0,0,0,0,0);
        add(0,1,0,0,0,            1,0,0,0,0,0);                       // IDLE -> FETCH
        add(0,1,0,0,0,            1,32'h4,32'h4,1,memWord(0),32'h4);
        add(0,1,0,0,0,            1,32'h8,32'h8,1,memWord(4),32'h8);
        add(0,1,0,0,0,            1,32'hC,32'hC,1,memWord(8),32'hC);
        add(0,0,0,0,0,            1,32'hC,32'hC,0,0,0);               // slow memory bubbles
        add(0,0,0,0,0,            1,32'hC,32'hC,0,0,0);
        add(0,1,0,0,0,            1,32'h10,32'h10,1,memWord(32'hC),32'h10);
        add(0,0,0,0,0,            1,32'h10,32'h10,0,0,0);
        add(0,0,0,0,0,            1,32'h10,32'h10,0,0,0);
        add(0,1,0,0,0,            1,32'h14,32'h14,1,memWord(32'h10),32'h14);
        add(0,1,1,0,0,            0,32'h14,32'h14,1,memWord(32'h10),32'h14); // -> HOLD
        add(0,0,1,0,0,            0,32'h14,32'h14,1,memWord(32'h10),32'h14);
        add(0,0,1,0,0,            0,32'h14,32'h14,1,memWord(32'h10),32'h14);
        add(0,0,0,0,0,            1,32'h18,32'h18,1,memWord(32'h14),32'h18); // buffer drains
        add(0,1,0,0,0,            1,32'h1C,32'h1C,1,memWord(32'h18),32'h1C);
        add(0,0,1,0,0,            1,32'h1C,32'h1C,1,memWord(32'h18),32'h1C); // stall, no ready
        add(0,1,0,0,0,            1,32'h20,32'h20,1,memWord(32'h1C),32'h20);
        add(0,1,1,1,32'h200,      1,32'h200,32'h200,0,0,0);           // redirect beats stall
        add(0,1,0,0,0,            1,32'h204,32'h204,1,memWord(32'h200),32'h204);
        add(0,1,1,0,0,            0,32'h204,32'h204,1,memWord(32'h200),32'h204); // HOLD
        add(0,0,1,1,32'h300,      1,32'h300,32'h300,0,0,0);           // redirect in HOLD
        add(0,1,0,0,0,            1,32'h304,32'h304,1,memWord(32'h300),32'h304);
        add(0,0,0,1,32'h100,      1,32'h304,32'h100,0,0,0);           // -> DROP
        add(0,0,1,0,0,            1,32'h304,32'h100,0,0,0);
        add(0,1,0,0,0,            1,32'h100,32'h100,0,0,0);           // late rdata dropped
        add(0,1,0,0,0,            1,32'h104,32'h104,1,memWord(32'h100),32'h104);
        add(0,0,0,1,32'h400,      1,32'h104,32'h400,0,0,0);
        add(0,0,0,1,32'h503,      1,32'h104,32'h500,0,0,0);           // last redirect wins
        add(0,1,0,0,0,            1,32'h500,32'h500,0,0,0);
        add(0,1,0,0,0,            1,32'h504,32'h504,1,memWord(32'h500),32'h504);
        add(0,1,0,1,32'hFFFF_FFFF,1,32'hFFFF_FFFC,32'hFFFF_FFFC,0,0,0);
        add(0,1,0,0,0,            1,32'h0,32'h0,1,memWord(32'hFFFF_FFFC),32'h0); // wrap
        add(0,1,0,0,0,            1,32'h4,32'h4,1,memWord(0),32'h4);
        add(0,0,0,1,32'h600,      1,32'h4,32'h600,0,0,0);             // DROP
        add(1,1,0,0,0,            0,0,0,0,0,0);                       // reset mid-DROP
        add(0,1,0,0,0,            1,0,0,0,0,0);
        add(0,1,0,0,0,            1,32'h4,32'h4,1,memWord(0),32'h4);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].stl, vecs[i].rdr, vecs[i].rpc);
            chk("imem_req", i, {31'h0, imem_req}, {31'h0, vecs[i].req});
            chk("imem_addr", i, imem_addr, vecs[i].addr);
            chk("pc", i, pc, vecs[i].pc);
            chk("if_id_valid", i, {31'h0, if_id_valid}, {31'h0, vecs[i].vld});
            chk("if_id_instr", i, if_id_instr, vecs[i].instr);
            chk("if_id_opcode", i, {26'h0, if_id_opcode}, {26'h0, vecs[i].instr[31:26]});
            if (vecs[i].vld) chk("if_id_pc4", i, if_id_pc4, vecs[i].pc4);
        end

        // Redirect with the request unanswered for several cycles: address must stay put.
        drive(0, 0, 0, 1, 32'h800);
        chk("drop_pc", 100, pc, 32'h800);
        chk("drop_addr", 100, imem_addr, 32'h4);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, k[0], 0, 0);
            chk("drop_addr_stable", 101 + k, imem_addr, 32'h4);
            chk("drop_req", 101 + k, {31'h0, imem_req}, 32'h1);
            chk("drop_valid", 101 + k, {31'h0, if_id_valid}, 32'h0);
            chk("drop_instr", 101 + k, if_id_instr, 32'h0);
        end
        drive(0, 1, 0, 0, 0);
        chk("drain_addr", 104, imem_addr, 32'h800);
        chk("drain_valid", 104, {31'h0, if_id_valid}, 32'h0);
        drive(0, 1, 0, 0, 0);
        chk("target_instr", 105, if_id_instr, 32'h8C00_0800);
        chk("target_opcode", 105, {26'h0, if_id_opcode}, 32'h23);
        chk("target_pc4", 105, if_id_pc4, 32'h804);
        chk("target_valid", 105, {31'h0, if_id_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core; the producer side of the main controller's decode interface.
- Holds the PC and issues requests to instruction memory over a ready handshake.
- Fills the IF/ID register whose opcode field drives the main controller.
- Accepts stall from the hazard unit and redirects (jump, taken beq/bne) from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0000, instruction placed in IF/ID on bubble or flush (sll $0,$0,0; opcode 6'h00)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned, stable while imem_req=1 and imem_ready=0
imem_ready  in  1  imem_rdata valid for the outstanding request
imem_rdata  in  32  fetched instruction
stall  in  1  hold IF/ID and PC (load-use hazard)
redirect  in  1  control-flow change; flush IF/ID
redirect_pc  in  32  new PC; bits [1:0] ignored, treated as 00
pc  out  32  current architectural fetch PC
if_id_instr  out  32  IF/ID instruction
if_id_opcode  out  6  if_id_instr[31:26], to main controller
if_id_pc4  out  32  PC+4 of the IF/ID instruction (jal link, branch base)
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, imem_addr=RESET_PC, imem_req=0.
  - if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, skid buffer empty, state=IDLE.
  - Reset takes effect in any state and abandons any outstanding request; a late imem_ready is ignored.
- Registered outputs: imem_req, imem_addr and all IF/ID fields are flops. if_id_opcode is combinational from if_id_instr.
- States: IDLE, FETCH, HOLD, DROP.
- IDLE: one cycle; next state FETCH with imem_req=1, imem_addr=pc. The first request appears the first cycle after rst deasserts.
- FETCH (imem_req=1). Priority: redirect > stall > normal.
  - redirect=1 and imem_ready=1: discard rdata; pc<=redirect_pc; imem_addr<=redirect_pc; IF/ID<=NOP, valid=0; stay FETCH.
  - redirect=1 and imem_ready=0: pc<=redirect_pc; imem_addr holds old address; IF/ID<=NOP, valid=0; go DROP.
  - imem_ready=1, stall=0: IF/ID<=rdata, pc4=pc+4, valid=1; pc<=pc+4; imem_addr<=pc+4; stay FETCH. With zero-wait memory this gives back-to-back throughput of one instruction per cycle.
  - imem_ready=1, stall=1: IF/ID holds; rdata goes to skid buffer; imem_req<=0; go HOLD.
  - imem_ready=0, stall=0: IF/ID<=NOP, valid=0 (bubble).
  - imem_ready=0, stall=1: IF/ID holds; imem_req stays 1.
- HOLD (imem_req=0; skid buffer full).
  - redirect=1: drop buffer; pc<=imem_addr<=redirect_pc; IF/ID<=NOP, valid=0; go FETCH.
  - stall=1: all registers hold.
  - stall=0: IF/ID<=buffer, pc4=pc+4, valid=1; pc<=imem_addr<=pc+4; go FETCH.
- DROP (imem_req=1, old address).
  - Wait for imem_ready, discard rdata, then imem_addr<=pc and go FETCH.
  - A further redirect in DROP only updates pc; the last redirect wins.
  - IF/ID stays NOP/invalid regardless of stall.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Invariant: at most one outstanding request; imem_addr never changes while imem_req=1 and imem_ready=0.
- When if_id_valid=0, if_id_instr is always NOP_INSTR, so the controller decodes R_Type with no memory write.

Test Plan:
1. rst for 2 cycles, then imem_ready tied 1 and memory returns addr-indexed words → imem_addr 0,4,8,C on consecutive cycles; if_id_valid=1 from cycle 3; if_id_pc4 4,8,C; if_id_opcode matches word[31:26] (e.g. 6'h23 for lw).
2. imem_ready asserted only every 3rd cycle → imem_addr stable between readies; IF/ID shows NOP/valid=0 bubbles between instructions; pc advances by 4 per ready only.
3. stall=1 for 3 cycles while a response lands → IF/ID unchanged during stall; imem_req=0 in HOLD; on stall release the buffered instruction enters IF/ID next cycle with correct pc4; no instruction lost or duplicated.
4. redirect=1 with redirect_pc=32'h0000_0100 while a request is outstanding and unready → state DROP; the late rdata is discarded; next imem_addr=0x100; IF/ID valid=0 until the 0x100 fetch returns.
5. stall=1 and redirect=1 together (in FETCH with ready=1, and in HOLD) → redirect wins; IF/ID flushed to NOP; pc=redirect_pc; skid buffer discarded.
6. redirect_pc=32'hFFFF_FFFF then sequential fetch → addresses FFFF_FFFC then 0000_0000; rst asserted mid-DROP → next cycle pc=RESET_PC, imem_req=0, if_id_valid=0.
